// File: rtl/rms_pkg.sv
// Shared constants and helpers for the mean-square / RMS datapath.
// Also imported by the sqrt stage, so keep the widths here authoritative.
package rms_pkg;

  localparam int DATA_W        = 8;   // signed input sample width
  localparam int SQ_W          = 15;  // unsigned square width (max 16384 at -128)
  localparam int OUT_SHIFT_DEF = 6;   // default post-mean scaling shift

  // Clamp an unsigned value to the 8-bit output range.
  function automatic logic [DATA_W-1:0] sat_u8(input logic [31:0] v);
    logic [DATA_W-1:0] r;
    if (v > 32'd255) r = '1;
    else             r = v[DATA_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mean_square_window_if.sv
// Sample-in / result-out bundle of the windowed mean-square block.
interface mean_square_window_if #(
  parameter int LOG2_N = 4
);
  import rms_pkg::*;

  logic                     clear;
  logic                     in_valid;
  logic signed [DATA_W-1:0] data_in;
  logic                     out_valid;
  logic [DATA_W-1:0]        data_out;
  logic [LOG2_N-1:0]        fill;

  modport master (
    output clear, in_valid, data_in,
    input  out_valid, data_out, fill
  );

  modport slave (
    input  clear, in_valid, data_in,
    output out_valid, data_out, fill
  );

endinterface

// File: rtl/signed_square_reg.sv
// Stage 1: registered square of a signed sample, with its valid flag.
module signed_square_reg
  import rms_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] data_in,
  output logic [SQ_W-1:0]          sq,
  output logic                     sq_valid
);

  logic signed [SQ_W-1:0] din_ext_p0;
  logic signed [SQ_W-1:0] prod_p0;

  // The true square never exceeds 2^14, so a SQ_W-bit product is exact.
  assign din_ext_p0 = {{(SQ_W-DATA_W){data_in[DATA_W-1]}}, data_in};
  assign prod_p0    = din_ext_p0 * din_ext_p0;

  // ---- p0 -> p1 ----
  // Capture the square; clear drops the sample presented in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq       <= '0;
      sq_valid <= 1'b0;
    end else begin
      sq_valid <= in_valid & ~clear;
      if (in_valid & ~clear) sq <= $unsigned(prod_p0);
    end
  end

endmodule

// File: rtl/mean_square_window.sv
// Block mean-square over non-overlapping windows of 2^LOG2_N valid samples,
// scaled by OUT_SHIFT and saturated to 8 bits for the sqrt stage.
module mean_square_window
  import rms_pkg::*;
#(
  parameter int LOG2_N    = 4,
  parameter int OUT_SHIFT = OUT_SHIFT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  mean_square_window_if.slave   bus
);

  localparam int ACC_W = SQ_W + LOG2_N;  // N squares of at most 2^14 never overflow

  logic [SQ_W-1:0]   sq_p1;
  logic              vld_p1;
  logic [ACC_W-1:0]  acc_p2;
  logic [LOG2_N-1:0] cnt_p2;
  logic [DATA_W-1:0] data_out_p2;
  logic              out_valid_p2;
  logic [ACC_W-1:0]  acc_sum;
  logic [ACC_W-1:0]  scaled;
  logic              win_done;

  signed_square_reg u_square (
    .clk      (clk),
    .reset    (reset),
    .clear    (bus.clear),
    .in_valid (bus.in_valid),
    .data_in  (bus.data_in),
    .sq       (sq_p1),
    .sq_valid (vld_p1)
  );

  // ---- p1 -> p2 ----
  assign acc_sum  = acc_p2 + {{LOG2_N{1'b0}}, sq_p1};
  assign win_done = vld_p1 && (&cnt_p2);
  // Mean (>> LOG2_N) then scaling (>> OUT_SHIFT), both floor, folded into one shift.
  assign scaled   = acc_sum >> (LOG2_N + OUT_SHIFT);

  // Accumulate squares; on the last one of a window emit the result and restart at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_p2       <= '0;
      cnt_p2       <= '0;
      data_out_p2  <= '0;
      out_valid_p2 <= 1'b0;
    end else if (bus.clear) begin
      acc_p2       <= '0;
      cnt_p2       <= '0;
      out_valid_p2 <= 1'b0;
    end else begin
      out_valid_p2 <= 1'b0;
      if (win_done) begin
        acc_p2       <= '0;
        cnt_p2       <= '0;
        data_out_p2  <= sat_u8({{(32-ACC_W){1'b0}}, scaled});
        out_valid_p2 <= 1'b1;
      end else if (vld_p1) begin
        acc_p2 <= acc_sum;
        cnt_p2 <= cnt_p2 + LOG2_N'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_p2;
  assign bus.data_out  = data_out_p2;
  assign bus.fill      = cnt_p2;

endmodule

// File: tb/tb_mean_square_window.sv
// Self-checking bench for mean_square_window (LOG2_N=4, OUT_SHIFT=6).
// Reference model: a queue holding the samples of the open window; when it
// holds 16 samples the expected result is floor(sum(x^2)/16/64) capped at 255,
// due two cycles after the last sample was presented.
module tb_mean_square_window;

  localparam int N = 16;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int win[$];
  int exp_val[$];
  int exp_cyc[$];
  int mon_val[$];
  int mon_cyc[$];
  int hold_exp = 0;
  int last_stamp = 0;

  mean_square_window_if #(.LOG2_N(4)) bus ();

  mean_square_window #(.LOG2_N(4), .OUT_SHIFT(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with the number of rising edges seen so far.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      mon_val.push_back(int'(bus.data_out));
      mon_cyc.push_back(cyc);
    end
  end

  task automatic model_step(input bit v, input int d, input bit c, input int stamp);
    int sum;
    int m;
    if (c) begin
      win.delete();
      for (int i = exp_cyc.size() - 1; i >= 0; i--)
        if (exp_cyc[i] == stamp + 1) begin
          exp_cyc.delete(i);
          exp_val.delete(i);
        end
    end else if (v) begin
      win.push_back(d);
      if (win.size() == N) begin
        sum = 0;
        foreach (win[i]) sum += win[i] * win[i];
        m = (sum / N) / 64;
        if (m > 255) m = 255;
        exp_val.push_back(m);
        exp_cyc.push_back(stamp + 2);
        win.delete();
      end
    end
  endtask

  task automatic drive(input bit v, input int d, input bit c);
    @(negedge clk);
    bus.in_valid = v;
    bus.data_in  = d[7:0];
    bus.clear    = c;
    last_stamp   = cyc;
    model_step(v, d, c, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, int'($urandom_range(0, 255)) - 128, 1'b0);
  endtask

  task automatic flush();
    if (exp_val.size() > 0) hold_exp = exp_val[exp_val.size() - 1];
    exp_val.delete();
    exp_cyc.delete();
    mon_val.delete();
    mon_cyc.delete();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    bus.clear    = 1'b0;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.data_in  = 8'd100;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    checks++;
    if (bus.data_out !== 8'd0) begin errors++; $display("FAIL reset_data_out: got %0d, expected 0", bus.data_out); end
    checks++;
    if (bus.fill !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d, expected 0", bus.fill); end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset        = 1'b0;
  endtask

  task automatic test_const16();
    int t_last;
    for (int i = 0; i < N; i++) drive(1'b1, 16, 1'b0);
    t_last = last_stamp;
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL const16_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL const16_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (mon_val.size() != 1 || mon_val[0] != 4 || mon_cyc[0] != t_last + 2) begin
      errors++; $display("FAIL const16_value: got %0d pulses, first %0d, expected one pulse of 4 at %0d", mon_val.size(), (mon_val.size() > 0) ? mon_val[0] : -1, t_last + 2);
    end
    checks++;
    if (bus.fill !== 4'd0) begin errors++; $display("FAIL const16_fill: got %0d, expected 0", bus.fill); end
    flush();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < N; i++) drive(1'b1, -128, 1'b0);
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL sat_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL sat_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (mon_val.size() != 1 || mon_val[0] != 255) begin errors++; $display("FAIL sat_value: got %0d pulses, expected one pulse of 255", mon_val.size()); end
    flush();
    checks++;
    if (int'(bus.data_out) !== hold_exp) begin errors++; $display("FAIL sat_hold: got %0d, expected %0d", bus.data_out, hold_exp); end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, (i % 2) ? 127 : 0, 1'b0);
      drive(1'b0, int'($urandom_range(0, 255)) - 128, 1'b0);
    end
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL gaps_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL gaps_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (mon_val.size() != 1 || mon_val[0] != 126) begin errors++; $display("FAIL gaps_value: got %0d pulses, expected one pulse of 126", mon_val.size()); end
    flush();
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) drive(1'b1, 100, 1'b0);
    idle(1);
    #1;
    checks++;
    if (int'(bus.fill) !== 4) begin errors++; $display("FAIL clear_partial_fill: got %0d, expected 4", bus.fill); end
    drive(1'b1, 100, 1'b1);
    for (int i = 0; i < N; i++) drive(1'b1, 8, 1'b0);
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL clear_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL clear_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (mon_val.size() != 1 || mon_val[0] != 1) begin errors++; $display("FAIL clear_value: got %0d pulses, expected one pulse of 1", mon_val.size()); end
    checks++;
    if (bus.fill !== 4'd0) begin errors++; $display("FAIL clear_fill: got %0d, expected 0", bus.fill); end
    flush();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * N; i++) drive(1'b1, 64, 1'b0);
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL b2b_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL b2b_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (mon_val.size() != 2 || mon_val[0] != 64 || mon_val[1] != 64 || mon_cyc[1] - mon_cyc[0] != N) begin
      errors++; $display("FAIL b2b_spacing: got %0d pulses, expected two pulses of 64 spaced %0d cycles", mon_val.size(), N);
    end
    flush();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10; i++) drive(1'b1, int'($urandom_range(0, 255)) - 128, 1'b0);
    drive(1'b0, 0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.data_out !== 8'd0) begin errors++; $display("FAIL arst_data_out: got %0d, expected 0", bus.data_out); end
    checks++;
    if (bus.fill !== 4'd0) begin errors++; $display("FAIL arst_fill: got %0d, expected 0", bus.fill); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b, expected 0", bus.out_valid); end
    win.delete();
    hold_exp = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) drive(1'b1, 32, 1'b0);
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL arst_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL arst_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (mon_val.size() != 1 || mon_val[0] != 16) begin errors++; $display("FAIL arst_value: got %0d pulses, expected one pulse of 16", mon_val.size()); end
    flush();
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) d = int'($urandom_range(0, 255)) - 128;
      else                           d = int'($urandom_range(0, 20)) - 10;
      drive(1'($urandom_range(0, 1)), d, ($urandom_range(0, 15) == 0));
    end
    idle(4);
    #1;
    checks++;
    if (mon_val.size() !== exp_val.size()) begin errors++; $display("FAIL rand_count: got %0d pulses, expected %0d", mon_val.size(), exp_val.size()); end
    for (int i = 0; i < mon_val.size() && i < exp_val.size(); i++) begin
      checks++;
      if (mon_val[i] !== exp_val[i] || mon_cyc[i] !== exp_cyc[i]) begin
        errors++; $display("FAIL rand_result[%0d]: got %0d at %0d, expected %0d at %0d", i, mon_val[i], mon_cyc[i], exp_val[i], exp_cyc[i]);
      end
    end
    checks++;
    if (int'(bus.fill) !== win.size()) begin errors++; $display("FAIL rand_fill: got %0d, expected %0d", bus.fill, win.size()); end
    flush();
    checks++;
    if (int'(bus.data_out) !== hold_exp) begin errors++; $display("FAIL rand_hold: got %0d, expected %0d", bus.data_out, hold_exp); end
  endtask

  initial begin
    test_reset();
    test_const16();
    test_saturate();
    test_gaps();
    test_clear();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mean_square_window.md
MEAN_SQUARE_WINDOW -- requirements
Module: mean_square_window

Interface
REQ-001 Parameter LOG2_N, default 4, meaning log2 of window length N (legal range 1..8).
REQ-002 Parameter OUT_SHIFT, default 6, meaning right shift applied to the window mean before output saturation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 clear  input  1  synchronous; discards the current partial window.
REQ-006 in_valid  input  1  data_in is a valid sample this cycle.
REQ-007 data_in  input  8  signed two's-complement sample.
REQ-008 out_valid  output  1  one-cycle pulse; data_out is a new result.
REQ-009 data_out  output  8  unsigned scaled mean-square, feeds the 8-bit sqrtFixedPoint data_in.
REQ-010 fill  output  LOG2_N  number of samples accumulated in the current window.

Function
REQ-011 Stage 1 shall register sq = data_in*data_in (15-bit unsigned; max 16384 at -128) together with sq_valid = in_valid.
REQ-012 Stage 2 shall add sq into a (15+LOG2_N)-bit accumulator when sq_valid, with no overflow possible.
REQ-013 A sample counter of LOG2_N bits shall increment per accepted square and wrap from N-1 to 0.
REQ-014 When the N-th square of a window is added, data_out shall register sat255(((acc+sq) >> LOG2_N) >> OUT_SHIFT) with truncation (floor), and out_valid shall pulse for exactly that cycle.
REQ-015 On that same edge the accumulator shall load 0 and the counter 0, so back-to-back windows have zero dead cycles.
REQ-016 Latency: out_valid shall be high in the 2nd cycle after the cycle in which the N-th sample was presented with in_valid=1.
REQ-017 in_valid gaps of any length shall not alter results; only valid samples count.
REQ-018 data_out shall hold its last value between out_valid pulses.
REQ-019 clear=1 shall, on that edge, zero the accumulator, counter and stage-1 sq_valid, and force out_valid=0; a sample presented in the same cycle is discarded (clear wins).
REQ-020 Saturation: any scaled mean > 255 shall output 255.
REQ-021 fill shall equal the counter value and read 0 immediately after a completed window.

Reset
REQ-022 While reset=1: sq, sq_valid, accumulator, counter, data_out, out_valid and fill shall all be 0, independent of clk.
REQ-023 Reset asserted mid-window shall discard the partial window; the first window after release starts at sample 0.
REQ-024 No out_valid pulse shall occur in the first two cycles after reset release.

Structure
REQ-025 Package rms_pkg shall hold DATA_W=8, SQ_W=15, the OUT_SHIFT default and the saturate-to-8-bit function, shared with the sqrt stage bench.
REQ-026 One sub-module, signed_square_reg (stage-1 registered squarer with valid), is natural; the accumulator, counter and output register shall stay in the top.
REQ-027 Target size is 120-400 RTL lines; no memories and no multi-cycle paths.

Verification (LOG2_N=4, OUT_SHIFT=6)
REQ-028 Directed: 16 consecutive samples of +16 -> one out_valid; data_out=4, at the 2nd cycle after the last sample.
REQ-029 Directed: 16 samples of -128 -> mean 16384, 16384>>6=256 -> data_out=255 (saturated).
REQ-030 Directed: alternating 0/127 for 16 valid samples, with in_valid low every other cycle -> data_out=126; no extra pulses.
REQ-031 Directed: 5 samples of 100, then clear together with a 6th sample, then 16 samples of 8 -> single out_valid with data_out=1.
REQ-032 Directed: 32 back-to-back samples of 64 -> two out_valid pulses exactly 16 cycles apart, both data_out=64.
REQ-033 Directed: reset asserted asynchronously after 10 samples -> outputs 0 immediately; 16 samples of 32 after release -> data_out=16.
